// File: rtl/ozone_core_pkg.sv
// ozone_core_pkg
//   Shared constants and types for the ozone_core AArch64-subset core:
//   line geometry, opcode field values for MOVZ / ADDS / HLT, the core
//   control state enum and a small opcode classifier.
//   Optional build macro used by the core: OZONE_INSTRET_EN.
package ozone_core_pkg;

    localparam int LINE_BYTES = 64;              // one instruction line, 16 words
    localparam int XLEN       = 64;
    localparam int LINE_BITS  = LINE_BYTES * 8;

    localparam logic [8:0]  OPCODE_MOVZ = 9'b110100101;    // insn[31:23]
    localparam logic [10:0] OPCODE_ADDS = 11'b10101011000; // insn[31:21]
    localparam logic [10:0] OPCODE_HLT  = 11'b11010100010; // insn[31:21]

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2,
        HALT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_MOVZ = 2'd0,
        OP_ADDS = 2'd1,
        OP_HLT  = 2'd2,
        OP_ILL  = 2'd3
    } op_t;

    function automatic op_t decode_op(input logic [31:0] insn);
        if (insn[31:23] == OPCODE_MOVZ)      return OP_MOVZ;
        else if (insn[31:21] == OPCODE_ADDS) return OP_ADDS;
        else if (insn[31:21] == OPCODE_HLT)  return OP_HLT;
        else                                 return OP_ILL;
    endfunction

endpackage

// File: rtl/ozone_core_alu.sv
// ozone_core_alu
//   Combinational execute unit: MOVZ immediate placement and 64-bit ADDS
//   with NZCV generation.
//   Ports:
//     i_sel_adds  1 = ADDS result, 0 = MOVZ result
//     i_hw        MOVZ halfword position (shift = 16*hw)
//     i_imm16     MOVZ immediate
//     i_a, i_b    ADDS operands (rn, rm values)
//     o_result    value written to rd
//     o_nzcv      flags {N,Z,C,V} for ADDS
module ozone_core_alu
    import ozone_core_pkg::*;
(
    input  logic            i_sel_adds,
    input  logic [1:0]      i_hw,
    input  logic [15:0]     i_imm16,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic [3:0]      o_nzcv
);

    logic [XLEN-1:0] w_movz;
    logic [XLEN:0]   w_sum;   // one extra bit holds the carry out
    logic [XLEN-1:0] w_res;

    assign w_movz = XLEN'(i_imm16) << {i_hw, 4'b0000};
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_res  = w_sum[XLEN-1:0];

    assign o_result = i_sel_adds ? w_res : w_movz;

    // Signed overflow: operands agree in sign but the result does not.
    assign o_nzcv = {w_res[XLEN-1],
                     (w_res == '0),
                     w_sum[XLEN],
                     (i_a[XLEN-1] == i_b[XLEN-1]) && (w_res[XLEN-1] != i_a[XLEN-1])};

endmodule

// File: rtl/ozone_core.sv
// ozone_core
//   In-order AArch64-subset core executing MOVZ, ADDS (shifted register,
//   shift amount ignored) and HLT in one cycle each from a single 64-byte
//   instruction line buffer filled by the last-level cache.
//   Ports:
//     clk_in, rst_N_in        clock, synchronous active-high reset
//     start, start_pc         one-cycle start pulse and entry PC
//     l1i_lc_*_in             instruction line fill from the LC
//     l1d_lc_*_in             data-side LC pins, ignored
//     l1i_req_valid_out/addr  line request while in MISS
//     cs_N_in, dbg_reg_*      debug register read port (active-low select)
//     pc_out, nzcv_out        architectural PC and flags
//     halted_out, illegal_out stop reason (HLT or unknown opcode)
//   Optional: define OZONE_INSTRET_EN to add instret_out, a retired
//   instruction counter (MOVZ/ADDS/HLT) cleared only by reset.
//   Line request handshake: l1i_req_valid_out rises on entry to MISS and
//   stays high until a cycle where l1i_lc_ready_in is also high; that cycle
//   transfers the request and the core then only waits for a fill whose
//   address matches the current PC line.
module ozone_core
    import ozone_core_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_N_in,
    input  logic                 cs_N_in,
    input  logic                 start,
    input  logic [XLEN-1:0]      start_pc,
    input  logic                 l1i_lc_ready_in,
    input  logic                 l1i_lc_valid_in,
    input  logic [XLEN-1:0]      l1i_lc_addr_in,
    input  logic [LINE_BITS-1:0] l1i_lc_value_in,
    input  logic                 l1d_lc_ready_in,
    input  logic                 l1d_lc_valid_in,
    input  logic [XLEN-1:0]      l1d_lc_addr_in,
    input  logic [LINE_BITS-1:0] l1d_lc_value_in,
    output logic                 l1i_req_valid_out,
    output logic [XLEN-1:0]      l1i_req_addr_out,
    input  logic [4:0]           dbg_reg_sel_in,
    output logic [XLEN-1:0]      dbg_reg_data_out,
    output logic [XLEN-1:0]      pc_out,
    output logic [3:0]           nzcv_out,
    output logic                 halted_out,
    output logic                 illegal_out
`ifdef OZONE_INSTRET_EN
    ,
    output logic [XLEN-1:0]      instret_out
`endif
);

    state_t                 r_state, w_state_nxt;
    logic [XLEN-1:0]        r_pc;
    logic [3:0]             r_nzcv;
    logic                   r_illegal;
    logic                   r_req_pending;
    logic [XLEN-1:0]        r_regs [0:31];   // entry 31 is never written
    logic [LINE_BITS-1:0]   r_line_data;
    logic [XLEN-7:0]        r_line_tag;
    logic                   r_line_valid;

    logic                   w_hit, w_fill_match, w_exec, w_wr_en;
    logic [31:0]            w_insn;
    op_t                    w_op;
    logic [4:0]             w_rd, w_rn, w_rm;
    logic [XLEN-1:0]        w_rn_val, w_rm_val, w_alu_res;
    logic [3:0]             w_alu_nzcv;
    logic                   w_unused;

    assign w_unused = ^{l1d_lc_ready_in, l1d_lc_valid_in, l1d_lc_addr_in,
                        l1d_lc_value_in, l1i_lc_addr_in[5:0]};

    assign w_hit        = r_line_valid && (r_line_tag == r_pc[XLEN-1:6]);
    assign w_fill_match = l1i_lc_valid_in && (l1i_lc_addr_in[XLEN-1:6] == r_pc[XLEN-1:6]);
    assign w_insn       = r_line_data[{r_pc[5:2], 5'b00000} +: 32];
    assign w_op         = decode_op(w_insn);
    assign w_rd         = w_insn[4:0];
    assign w_rn         = w_insn[9:5];
    assign w_rm         = w_insn[20:16];
    assign w_rn_val     = (w_rn == 5'd31) ? '0 : r_regs[w_rn];
    assign w_rm_val     = (w_rm == 5'd31) ? '0 : r_regs[w_rm];
    assign w_exec       = (r_state == RUN) && w_hit;
    assign w_wr_en      = w_exec && ((w_op == OP_MOVZ) || (w_op == OP_ADDS)) && (w_rd != 5'd31);

    ozone_core_alu u_alu (
        .i_sel_adds (w_op == OP_ADDS),
        .i_hw       (w_insn[22:21]),
        .i_imm16    (w_insn[20:5]),
        .i_a        (w_rn_val),
        .i_b        (w_rm_val),
        .o_result   (w_alu_res),
        .o_nzcv     (w_alu_nzcv)
    );

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_N_in) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN: begin
                if (!w_hit)                                    w_state_nxt = MISS;
                else if ((w_op == OP_HLT) || (w_op == OP_ILL)) w_state_nxt = HALT;
            end
            // A line already resident (filled in the same cycle as the miss
            // check) also resumes, so the core never waits for a second fill.
            MISS: if (w_hit || w_fill_match) w_state_nxt = RUN;
            HALT: if (start) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Architectural state and line buffer
    always_ff @(posedge clk_in) begin
        if (rst_N_in) begin
            r_pc          <= '0;
            r_nzcv        <= '0;
            r_illegal     <= 1'b0;
            r_req_pending <= 1'b0;
            r_line_data   <= '0;
            r_line_tag    <= '0;
            r_line_valid  <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            if (l1i_lc_valid_in) begin
                r_line_data  <= l1i_lc_value_in;
                r_line_tag   <= l1i_lc_addr_in[XLEN-1:6];
                r_line_valid <= 1'b1;
            end
            if (w_wr_en) r_regs[w_rd] <= w_alu_res;
            case (r_state)
                IDLE: if (start) r_pc <= start_pc;
                HALT: if (start) begin
                    r_pc      <= start_pc;
                    r_illegal <= 1'b0;
                end
                RUN: begin
                    if (!w_hit) begin
                        r_req_pending <= 1'b1;
                    end else begin
                        case (w_op)
                            OP_MOVZ: r_pc <= r_pc + 64'd4;
                            OP_ADDS: begin
                                r_pc   <= r_pc + 64'd4;
                                r_nzcv <= w_alu_nzcv;
                            end
                            OP_HLT:  ;                    // PC stays on the HLT
                            default: r_illegal <= 1'b1;   // PC stays on the bad word
                        endcase
                    end
                end
                MISS: begin
                    if (w_state_nxt != MISS)       r_req_pending <= 1'b0;
                    else if (l1i_lc_ready_in)      r_req_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef OZONE_INSTRET_EN
    logic [XLEN-1:0] r_instret;
    always_ff @(posedge clk_in) begin
        if (rst_N_in)                        r_instret <= '0;
        else if (w_exec && (w_op != OP_ILL)) r_instret <= r_instret + 64'd1;
    end
    assign instret_out = r_instret;
`endif

    // Outputs
    always_comb begin
        l1i_req_valid_out = (r_state == MISS) && r_req_pending;
        l1i_req_addr_out  = {r_pc[XLEN-1:6], 6'b000000};
        pc_out            = r_pc;
        nzcv_out          = r_nzcv;
        halted_out        = (r_state == HALT) && !r_illegal;
        illegal_out       = (r_state == HALT) && r_illegal;
        dbg_reg_data_out  = '0;
        if (!cs_N_in && (dbg_reg_sel_in != 5'd31)) dbg_reg_data_out = r_regs[dbg_reg_sel_in];
    end

endmodule

// File: tb/tb_ozone_core.sv
module tb_ozone_core;

  logic         clk_in = 1'b0;
  logic         rst_N_in, cs_N_in, start;
  logic [63:0]  start_pc;
  logic         l1i_lc_ready_in, l1i_lc_valid_in;
  logic [63:0]  l1i_lc_addr_in;
  logic [511:0] l1i_lc_value_in;
  logic         l1d_lc_ready_in, l1d_lc_valid_in;
  logic [63:0]  l1d_lc_addr_in;
  logic [511:0] l1d_lc_value_in;
  logic         l1i_req_valid_out;
  logic [63:0]  l1i_req_addr_out;
  logic [4:0]   dbg_reg_sel_in;
  logic [63:0]  dbg_reg_data_out, pc_out;
  logic [3:0]   nzcv_out;
  logic         halted_out, illegal_out;
`ifdef OZONE_INSTRET_EN
  logic [63:0]  instret_out;
`endif

  always #5 clk_in = ~clk_in;

  ozone_core dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in), .cs_N_in(cs_N_in), .start(start), .start_pc(start_pc),
    .l1i_lc_ready_in(l1i_lc_ready_in), .l1i_lc_valid_in(l1i_lc_valid_in),
    .l1i_lc_addr_in(l1i_lc_addr_in), .l1i_lc_value_in(l1i_lc_value_in),
    .l1d_lc_ready_in(l1d_lc_ready_in), .l1d_lc_valid_in(l1d_lc_valid_in),
    .l1d_lc_addr_in(l1d_lc_addr_in), .l1d_lc_value_in(l1d_lc_value_in),
    .l1i_req_valid_out(l1i_req_valid_out), .l1i_req_addr_out(l1i_req_addr_out),
    .dbg_reg_sel_in(dbg_reg_sel_in), .dbg_reg_data_out(dbg_reg_data_out),
    .pc_out(pc_out), .nzcv_out(nzcv_out), .halted_out(halted_out), .illegal_out(illegal_out)
`ifdef OZONE_INSTRET_EN
    , .instret_out(instret_out)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // ---------------- ISA-level reference model ----------------
  logic [63:0] m_regs[32];
  logic [3:0]  m_nzcv;
  logic [63:0] m_pc, m_instret;
  logic        m_halted, m_illegal;
  logic [31:0] m_line[16];
  logic [57:0] m_tag;
  logic        m_valid;
  logic [31:0] prog[16];

  function automatic logic [31:0] enc_movz(input logic [4:0] rd, input logic [15:0] imm, input logic [1:0] hw);
    return {9'h1A5, hw, imm, rd};
  endfunction
  function automatic logic [31:0] enc_adds(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm, input logic [5:0] imm6);
    return {11'h558, rm, imm6, rn, rd};
  endfunction
  function automatic logic [31:0] enc_hlt(input logic [20:0] imm);
    return {11'h6A2, imm};
  endfunction

  function automatic logic [63:0] m_reg(input logic [4:0] r);
    return (r == 5'd31) ? 64'd0 : m_regs[r];
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_nzcv = 4'd0; m_pc = 64'd0; m_instret = 64'd0;
    m_halted = 1'b0; m_illegal = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_run(input logic [63:0] pc0);
    logic [31:0] w;
    logic [64:0] full;
    logic [63:0] a, b, res;
    logic        stop;
    m_pc = pc0; m_halted = 1'b0; m_illegal = 1'b0; stop = 1'b0;
    for (int step = 0; step < 40 && !stop; step++) begin
      if (!m_valid || m_tag != m_pc[63:6]) begin
        stop = 1'b1;
      end else begin
        w = m_line[m_pc[5:2]];
        if (w[31:23] == 9'h1A5) begin
          res = 64'(w[20:5]) * (64'd1 << (16 * w[22:21]));
          if (w[4:0] != 5'd31) m_regs[w[4:0]] = res;
          m_pc = m_pc + 64'd4; m_instret++;
        end else if (w[31:21] == 11'h558) begin
          a = m_reg(w[9:5]); b = m_reg(w[20:16]);
          full = {1'b0, a} + {1'b0, b};
          res = full[63:0];
          m_nzcv = {$signed(res) < 0, res == 64'd0, full[64],
                    (($signed(a) < 0) == ($signed(b) < 0)) && (($signed(res) < 0) != ($signed(a) < 0))};
          if (w[4:0] != 5'd31) m_regs[w[4:0]] = res;
          m_pc = m_pc + 64'd4; m_instret++;
        end else if (w[31:21] == 11'h6A2) begin
          m_halted = 1'b1; stop = 1'b1; m_instret++;
        end else begin
          m_illegal = 1'b1; stop = 1'b1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset;
    rst_N_in = 1'b1;
    @(negedge clk_in);
    rst_N_in = 1'b0;
    model_reset();
  endtask

  task automatic fill_line(input logic [63:0] addr);
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = prog[k];
    l1i_lc_valid_in = 1'b1; l1i_lc_addr_in = addr; l1i_lc_value_in = v;
    @(negedge clk_in);
    l1i_lc_valid_in = 1'b0;
    for (int k = 0; k < 16; k++) m_line[k] = prog[k];
    m_tag = addr[63:6]; m_valid = 1'b1;
  endtask

  task automatic start_core(input logic [63:0] pc);
    start = 1'b1; start_pc = pc;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_stop(input int bound, output int cyc);
    cyc = 1;
    while (!(halted_out || illegal_out) && cyc < bound) begin
      @(negedge clk_in);
      cyc++;
    end
    check("stopped", {63'd0, halted_out | illegal_out}, 64'd1);
  endtask

  task automatic wait_req(input int bound);
    int c = 0;
    while (!l1i_req_valid_out && c < bound) begin
      @(negedge clk_in);
      c++;
    end
    check("req_valid", {63'd0, l1i_req_valid_out}, 64'd1);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) exp_q.push_back(m_reg(5'(i)));
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_in);
      cs_N_in = 1'b0; dbg_reg_sel_in = 5'(i);
      #1;
      check($sformatf("%s_x%0d", tag, i), dbg_reg_data_out, exp_q.pop_front());
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"}, pc_out, m_pc);
    check({tag, "_nzcv"}, {60'd0, nzcv_out}, {60'd0, m_nzcv});
    check({tag, "_halted"}, {63'd0, halted_out}, {63'd0, m_halted});
    check({tag, "_illegal"}, {63'd0, illegal_out}, {63'd0, m_illegal});
`ifdef OZONE_INSTRET_EN
    check({tag, "_instret"}, instret_out, m_instret);
`endif
    check_regs(tag);
  endtask

  task automatic gen_random_prog;
    int sel;
    for (int k = 0; k < 15; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)
        prog[k] = enc_movz(5'($urandom_range(0, 31)), 16'($urandom), 2'($urandom_range(0, 3)));
      else if (sel < 9)
        prog[k] = enc_adds(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                           5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
      else
        prog[k] = $urandom & 32'h001F_FFFF;
    end
    prog[15] = enc_hlt(21'($urandom));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    logic [63:0] addr;
    logic [63:0] spc;
    rst_N_in = 1'b1; cs_N_in = 1'b1; start = 1'b0; start_pc = 64'd0;
    l1i_lc_ready_in = 1'b0; l1i_lc_valid_in = 1'b0; l1i_lc_addr_in = 64'd0; l1i_lc_value_in = '0;
    l1d_lc_ready_in = 1'b0; l1d_lc_valid_in = 1'b0; l1d_lc_addr_in = 64'd0; l1d_lc_value_in = '0;
    dbg_reg_sel_in = 5'd0;
    do_reset();

    // reset state
    cs_N_in = 1'b0; #1;
    check("rst_pc", pc_out, 64'd0);
    check("rst_nzcv", {60'd0, nzcv_out}, 64'd0);
    check("rst_halted", {63'd0, halted_out}, 64'd0);
    check("rst_illegal", {63'd0, illegal_out}, 64'd0);
    check("rst_req", {63'd0, l1i_req_valid_out}, 64'd0);
    check("rst_req_addr", l1i_req_addr_out, 64'd0);
    check("rst_dbg", dbg_reg_data_out, 64'd0);

    // program test
    for (int k = 0; k < 16; k++) prog[k] = 32'd0;
    prog[0] = enc_movz(5'd0, 16'hFFFF, 2'd0);
    prog[1] = enc_movz(5'd1, 16'hFFFF, 2'd1);
    prog[2] = enc_movz(5'd2, 16'hFFFF, 2'd3);
    prog[3] = enc_movz(5'd3, 16'hFFFF, 2'd2);
    prog[4] = enc_movz(5'd4, 16'h0001, 2'd0);
    prog[5] = enc_adds(5'd5, 5'd0, 5'd1, 6'd0);
    prog[6] = enc_adds(5'd6, 5'd2, 5'd3, 6'd0);
    prog[7] = enc_adds(5'd7, 5'd5, 5'd6, 6'd0);
    prog[8] = enc_adds(5'd8, 5'd4, 5'd7, 6'd0);
    prog[9] = enc_hlt(21'd0);
    fill_line(64'd0);
    start_core(64'd0);
    wait_stop(30, cyc);
    check("prog_latency_le11", {63'd0, cyc <= 11}, 64'd1);
    check("prog_pc", pc_out, 64'h24);
    check("prog_nzcv", {60'd0, nzcv_out}, 64'h6);
    check("prog_halted", {63'd0, halted_out}, 64'd1);
    model_run(64'd0);
    check_state("prog");
    cs_N_in = 1'b0; dbg_reg_sel_in = 5'd5; #1; check("prog_x5", dbg_reg_data_out, 64'hFFFF_FFFF);
    dbg_reg_sel_in = 5'd6; #1; check("prog_x6", dbg_reg_data_out, 64'hFFFF_FFFF_0000_0000);
    dbg_reg_sel_in = 5'd7; #1; check("prog_x7", dbg_reg_data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    dbg_reg_sel_in = 5'd8; #1; check("prog_x8", dbg_reg_data_out, 64'd0);

    // debug port
    cs_N_in = 1'b1; dbg_reg_sel_in = 5'd1; #1; check("dbg_cs_high", dbg_reg_data_out, 64'd0);
    cs_N_in = 1'b0; #1; check("dbg_x1", dbg_reg_data_out, 64'hFFFF_0000);
    dbg_reg_sel_in = 5'd31; #1; check("dbg_sel31", dbg_reg_data_out, 64'd0);

    // illegal word 0 at 0x28, restart from HALT keeps registers
    @(negedge clk_in);
    start_core(64'h28);
    wait_stop(10, cyc);
    check("ill_illegal", {63'd0, illegal_out}, 64'd1);
    check("ill_halted", {63'd0, halted_out}, 64'd0);
    check("ill_pc", pc_out, 64'h28);
    model_run(64'h28);
    check_state("ill");

    // ADDS signed overflow
    for (int k = 0; k < 16; k++) prog[k] = 32'd0;
    prog[0] = enc_movz(5'd10, 16'hFFFF, 2'd0);
    prog[1] = enc_movz(5'd11, 16'hFFFF, 2'd1);
    prog[2] = enc_adds(5'd12, 5'd10, 5'd11, 6'd0);
    prog[3] = enc_movz(5'd13, 16'hFFFF, 2'd2);
    prog[4] = enc_adds(5'd12, 5'd12, 5'd13, 6'd5);
    prog[5] = enc_movz(5'd13, 16'h7FFF, 2'd3);
    prog[6] = enc_adds(5'd12, 5'd12, 5'd13, 6'd0);
    prog[7] = enc_movz(5'd14, 16'h0001, 2'd0);
    prog[8] = enc_adds(5'd15, 5'd12, 5'd14, 6'd0);
    prog[9] = enc_hlt(21'd7);
    fill_line(64'h80);
    start_core(64'h80);
    wait_stop(30, cyc);
    check("ovf_nzcv", {60'd0, nzcv_out}, 64'h9);
    cs_N_in = 1'b0; dbg_reg_sel_in = 5'd15; #1; check("ovf_x15", dbg_reg_data_out, 64'h8000_0000_0000_0000);
    model_run(64'h80);
    check_state("ovf");

    // miss with a delayed ready, then a fill resumes execution
    @(negedge clk_in);
    start_core(64'h40);
    wait_req(5);
    check("miss_addr", l1i_req_addr_out, 64'h40);
    repeat (3) @(negedge clk_in);
    check("miss_hold", {63'd0, l1i_req_valid_out}, 64'd1);
    l1i_lc_ready_in = 1'b1;
    @(negedge clk_in);
    l1i_lc_ready_in = 1'b0;
    check("miss_drop", {63'd0, l1i_req_valid_out}, 64'd0);
    check("miss_not_halted", {63'd0, halted_out}, 64'd0);
    for (int k = 0; k < 16; k++) prog[k] = 32'd0;
    prog[0] = enc_movz(5'd20, 16'h1234, 2'd1);
    prog[1] = enc_adds(5'd21, 5'd20, 5'd20, 6'd0);
    prog[2] = enc_hlt(21'd1);
    fill_line(64'h40);
    wait_stop(20, cyc);
    check("miss_pc", pc_out, 64'h48);
    model_run(64'h40);
    check_state("miss");

    // reset in the middle of a run
    for (int k = 0; k < 15; k++) prog[k] = enc_movz(5'(k), 16'(k + 1), 2'(k));
    prog[15] = enc_hlt(21'd0);
    fill_line(64'hC0);
    start_core(64'hC0);
    repeat (2) @(negedge clk_in);
    do_reset();
    check("mrst_pc", pc_out, 64'd0);
    check("mrst_nzcv", {60'd0, nzcv_out}, 64'd0);
    check("mrst_halted", {63'd0, halted_out}, 64'd0);
    check("mrst_req", {63'd0, l1i_req_valid_out}, 64'd0);
    check_state("mrst");
    start_core(64'h40);
    wait_req(5);
    check("mrst_req_addr", l1i_req_addr_out, 64'h40);
    do_reset();
    check("mrst2_req", {63'd0, l1i_req_valid_out}, 64'd0);

    // randomized programs against the model (registers carry over runs)
    for (int it = 0; it < 20; it++) begin
      gen_random_prog();
      addr = {$urandom, $urandom};
      addr[5:0] = 6'd0;
      spc = addr + 64'(4 * $urandom_range(0, 15));
      fill_line(addr);
      start_core(spc);
      wait_stop(30, cyc);
      model_run(spc);
      check_state($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ozone_core.md
Name: ozone_core

Overview:
- Minimal in-order AArch64-subset core: single-cycle execute of MOVZ, ADDS (shifted-register, LSL #0) and HLT.
- Instructions come from a one-line (64-byte) instruction line buffer filled by the last-level cache (LC) over the L1I fill interface.
- Sits at the processor top level between the LC and the debug/control harness.
- The data-side LC interface is present for pin compatibility only; this core has no loads or stores.

Parameters:
- LINE_BYTES, 64, instruction line size in bytes (16 instructions).
- XLEN, 64, register and PC width.

Ports:
- clk_in  input  1  clock
- rst_N_in  input  1  reset; synchronous, active-high (name kept from codebase)
- cs_N_in  input  1  active-low chip select for debug read port
- start  input  1  one-cycle start pulse
- start_pc  input  64  PC loaded on start
- l1i_lc_ready_in  input  1  LC can accept a line request
- l1i_lc_valid_in  input  1  LC fill valid this cycle
- l1i_lc_addr_in  input  64  fill line address
- l1i_lc_value_in  input  512  fill data; instruction k at bits [32k+31:32k]
- l1d_lc_ready_in, l1d_lc_valid_in  input  1 each  unused, ignored
- l1d_lc_addr_in  input  64  unused, ignored
- l1d_lc_value_in  input  512  unused, ignored
- l1i_req_valid_out  output  1  line request valid
- l1i_req_addr_out  output  64  requested line address, {pc[63:6],6'b0}
- dbg_reg_sel_in  input  5  debug register index
- dbg_reg_data_out  output  64  register value; 0 when cs_N_in=1 or sel=31
- pc_out  output  64  current PC
- nzcv_out  output  4  flags {N,Z,C,V}
- halted_out  output  1  core stopped on HLT
- illegal_out  output  1  core stopped on an unknown opcode

Behaviour:
- Reset (rst_N_in=1 at posedge): state IDLE; x0..x30=0; PC=0; NZCV=0; line buffer invalid; all outputs 0.
- Reset mid-run: aborts everything, including any outstanding request.
- Fill capture: any cycle with l1i_lc_valid_in=1, in any state, writes data and tag addr[63:6] and sets valid. A single buffer: each new fill replaces the old one.
- States:
  - IDLE: start moves to RUN with PC=start_pc.
  - RUN: hit means valid and tag==pc[63:6]. On a hit, decode word pc[5:2] and execute in one cycle; register and flag writes and PC+4 take effect at the edge. On a miss, go to MISS. Start is ignored in RUN.
  - MISS: hold l1i_req_valid_out=1 until l1i_lc_ready_in=1 (handshake cycle); then drop the request and wait. A fill whose tag matches returns the core to RUN. Same-cycle fill and RUN check: the fill is visible on the following cycle.
  - HALT: start restarts at start_pc with registers and flags retained; halted_out and illegal_out clear.
- Decode:
  - MOVZ: [31:23]=110100101, hw=[22:21], imm16=[20:5], rd=[4:0]. Result rd=imm16<<(16*hw).
  - ADDS: [31:21]=10101011000, rm=[20:16], imm6=[15:10] (ignored, treated as 0), rn=[9:5], rd=[4:0].
    - 65-bit add rn+rm.
    - N=res[63]; Z=(res==0); C=carry out; V=(a63==b63)&&(res63!=a63).
  - HLT: [31:21]=11010100010. State to HALT; halted_out=1; PC stays at the HLT address.
  - Any other word: state to HALT; illegal_out=1; PC stays.
- Register 31 reads as zero; writes to register 31 are discarded.
- Writes are visible to the next instruction with no hazard stall.

Optional Feature:
- OZONE_INSTRET_EN defined: adds output instret_out[63:0]. It counts MOVZ/ADDS/HLT retirements, is reset to 0, and is not cleared by start.
- Undefined: the port and counter are absent.

Decomposition:
- Package ozone_core_pkg holds:
  - constants OPCODE_MOVZ (9 bits), OPCODE_ADDS (11 bits), OPCODE_HLT (11 bits);
  - the state enum {IDLE, RUN, MISS, HALT};
  - the LINE_BYTES constant.
- One natural sub-module: ozone_core_alu (MOVZ shift and ADDS add with NZCV generation).

Test Plan:
- Program test: fill line at addr 0, then start with start_pc=0. Line contents:
  - movz x0,#0xFFFF hw0; x1 hw1; x2 hw3; x3 hw2; x4=1;
  - adds x5=x0+x1; x6=x2+x3; x7=x5+x6; x8=x4+x7; hlt.
  - Required: halted_out within 11 cycles after start; pc_out=0x24.
  - Required registers: x5=0xFFFFFFFF; x6=0xFFFFFFFF00000000; x7=0xFFFF_FFFF_FFFF_FFFF; x8=0; nzcv=4'b0110.
- Miss test: start_pc=0x40 with no fill. Required: l1i_req_valid_out=1 with addr 0x40, held until ready. Supplying a fill at 0x40 resumes execution.
- Debug port: cs_N_in=1 -> dbg_reg_data_out=0. cs_N_in=0 with sel=1 after the program -> 0xFFFF0000.
- Illegal opcode word 0 -> illegal_out=1, halted_out=0, pc_out=address of that word.
- Reset asserted mid-run -> next cycle all registers 0, outputs 0, state IDLE. A start after reset with no fill produces a miss request.
- ADDS overflow: 0x7FFF…FFFF+1 -> nzcv=4'b1001.
